iob_nco_period_meter: RTL and testbench
=======================================

Name: iob_nco_period_meter

Overview:
- Measures the period of a slow periodic input, such as the clk_out_o of iob_nco, in cycles of the system clock. Acts as the receive-side counterpart to the NCO.
- Averages over 2^avg_log2_i input periods and reports the result as an integer part plus a 0.DATA_W binary fraction. This is the same int/frac format the NCO period registers use.
- Sits beside iob_nco in a peripheral and feeds its CSR block or self-check logic.

Parameters:
DATA_W, 32, width of the cycle counter, period_int_o and period_frac_o
AVG_LOG2_W, 3, width of avg_log2_i; at most 2^(2^AVG_LOG2_W-1) periods are averaged
SYNC_STAGES, 2, synchroniser depth on sig_i (minimum 2)

Ports:
clk_i  input  1  system clock
cke_i  input  1  clock enable; when low, all state is frozen
arst_n_i  input  1  asynchronous active-low reset
sig_i  input  1  signal to be measured; asynchronous to clk_i
enable_i  input  1  measurement enable
avg_log2_i  input  AVG_LOG2_W  log2 of the number of periods per window; must be < DATA_W
period_int_o  output  DATA_W  integer part of the averaged period, in clk_i cycles
period_frac_o  output  DATA_W  fractional part of the averaged period, MSB weight = 1/2
valid_o  output  1  result available
ready_i  input  1  consumer accepts the result
overrun_o  output  1  sticky: a result was overwritten while unconsumed
timeout_o  output  1  sticky: counter saturated with no closing edge
clear_i  input  1  clears overrun_o and timeout_o

Behaviour:
- Reset (arst_n_i=0, asynchronous): all outputs are 0, the FSM is in IDLE, and the synchroniser flops are 0.
- Input path:
  - sig_i passes through SYNC_STAGES flops, then one delay flop.
  - rise = synced & ~delayed.
  - The fixed latency of SYNC_STAGES+1 cycles does not affect the measured period.
- FSM states:
  - IDLE: leave to ARM when enable_i=1.
  - ARM:
    - On rise: cnt<=0, edges<=0, latch avg_log2_i into avg_q, go to MEASURE.
    - enable_i=0: go to IDLE.
  - MEASURE, on every cke cycle:
    - No rise: cnt<=cnt+1.
    - rise and edges+1 < 2^avg_q: edges<=edges+1, cnt<=cnt+1.
    - rise and edges+1 == 2^avg_q (window close):
      - total = cnt+1.
      - period_int_o <= total >> avg_q.
      - period_frac_o <= (total << (DATA_W-avg_q)) truncated to DATA_W bits; this is 0 when avg_q=0.
      - valid_o<=1.
      - cnt<=0, edges<=0, avg_q<=avg_log2_i. The closing edge opens the next window back-to-back, with no lost edge.
    - cnt==2^DATA_W-1 with no closing rise: timeout_o<=1, no result, go to ARM.
    - enable_i=0: go to IDLE. The partial window is discarded; outputs and flags hold.
- Example: a constant period of P cycles with avg_q=0 yields period_int_o=P and period_frac_o=0.
- Handshake:
  - valid_o stays high until a cycle with valid_o&ready_i, which clears it on the next edge.
  - If a window closes in the same cycle as the accept, the new result loads, valid_o stays 1, and there is no overrun.
  - If a window closes while valid_o=1 and ready_i=0, the result is overwritten and overrun_o<=1.
- Flags:
  - clear_i clears overrun_o and timeout_o.
  - If clear_i and a set event occur in the same cycle, set wins.
- cke_i=0: the synchroniser, counters, FSM and outputs all hold. Edges that occur during this time may be missed; this is acceptable.
- avg_log2_i changes take effect only at the next window start.

Test Plan:
- sig_i with period 10 clk_i cycles, avg_log2_i=0, enable -> first result valid_o=1, period_int_o=10, period_frac_o=0; every later result identical; ready_i held 1 -> overrun_o stays 0.
- sig_i driven by iob_nco clk_out with PERIOD_INT=0x12, PERIOD_FRAC=0x80000000, with the NCO clock domain tied to clk_i, avg_log2_i=1 -> period_int_o=18, period_frac_o=0x80000000.
- Same stimulus with avg_log2_i=3 -> period_int_o=18, period_frac_o=0x80000000; a change of avg_log2_i to 0 mid-window is applied only at the next window; results then alternate 18/19 with frac 0.
- ready_i=0 for two full windows -> overrun_o=1 and the second result is shown; pulse clear_i -> overrun_o=0; one ready_i cycle -> valid_o=0.
- DATA_W=8, sig_i stuck high after one rise -> after 255 cycles timeout_o=1, FSM in ARM, valid_o unchanged; the next two rises 20 cycles apart -> valid_o with period_int_o=20.
- arst_n_i pulsed low mid-window -> all outputs 0 immediately; enable_i low mid-window -> no result, FSM in IDLE; re-enable -> a correct measurement after one arming edge.

Source files
------------

// File: rtl/iob_nco_period_meter_if.sv
// Result channel of the NCO period meter: averaged period (int/frac) with a
// valid/ready handshake. The meter drives it through the master modport; the
// consumer (CSR block or self-check logic) uses the slave modport.
interface iob_nco_period_meter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] period_int_o;
  logic [DATA_W-1:0] period_frac_o;
  logic              valid_o;
  logic              ready_i;

  modport master (
    output period_int_o,
    output period_frac_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  period_int_o,
    input  period_frac_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/iob_nco_period_meter.sv
// Period meter for a slow periodic input (e.g. the NCO clock output).
// Counts system clock cycles over 2^avg_q input periods and reports the
// average as an integer part plus a 0.DATA_W binary fraction, which matches
// the int/frac format of the NCO period registers.
module iob_nco_period_meter #(
  parameter int DATA_W      = 32,
  parameter int AVG_LOG2_W  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_n_i,
  input  logic                  sig_i,
  input  logic                  enable_i,
  input  logic [AVG_LOG2_W-1:0] avg_log2_i,
  iob_nco_period_meter_if.master res_if,
  output logic                  overrun_o,
  output logic                  timeout_o,
  input  logic                  clear_i
);

  // Edge counter must hold 2^avg_q for the largest avg_q, plus one spare bit.
  localparam int EDGE_W = (1 << AVG_LOG2_W) + 1;
  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_delay;
  logic [DATA_W-1:0]      r_cnt;
  logic [EDGE_W-1:0]      r_edges;
  logic [AVG_LOG2_W-1:0]  r_avgQ;
  logic [DATA_W-1:0]      r_periodInt;
  logic [DATA_W-1:0]      r_periodFrac;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   r_timeout;

  logic                   w_rise;
  logic [EDGE_W-1:0]      w_edgesInc;
  logic [EDGE_W-1:0]      w_target;
  logic                   w_close;
  logic [DATA_W:0]        w_total;

  // Bring the asynchronous input into the clock domain and keep one extra
  // delayed copy so a rising edge can be detected on the synchronised value.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_sync  <= '0;
      r_delay <= 1'b0;
    end else if (cke_i) begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_i};
      r_delay <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_delay;
  assign w_edgesInc = r_edges + EDGE_W'(1);
  assign w_target   = EDGE_W'(1) << r_avgQ;
  assign w_close    = w_rise && (w_edgesInc == w_target);
  // One extra bit so a window closing exactly at counter saturation is not lost.
  assign w_total    = {1'b0, r_cnt} + (DATA_W+1)'(1);

  // Measurement FSM: arms on a rising edge, counts cycles across 2^avg_q
  // periods, publishes the scaled result and restarts on the closing edge.
  // Also owns the result handshake and the sticky overrun/timeout flags.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_edges      <= '0;
      r_avgQ       <= '0;
      r_periodInt  <= '0;
      r_periodFrac <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else if (cke_i) begin
      if (r_valid && res_if.ready_i) begin
        r_valid <= 1'b0;
      end
      if (clear_i) begin
        r_overrun <= 1'b0;
        r_timeout <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            r_state <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_edges <= '0;
            r_avgQ  <= avg_log2_i;
            r_state <= ST_MEASURE;
          end else if (!enable_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_MEASURE: begin
          if (!enable_i) begin
            r_state <= ST_IDLE;
          end else if (w_close) begin
            r_periodInt  <= DATA_W'(w_total >> r_avgQ);
            r_periodFrac <= DATA_W'(w_total << (DATA_W - int'(r_avgQ)));
            r_valid      <= 1'b1;
            if (r_valid && !res_if.ready_i) begin
              r_overrun <= 1'b1;
            end
            r_cnt   <= '0;
            r_edges <= '0;
            r_avgQ  <= avg_log2_i;
          end else if (r_cnt == CNT_MAX) begin
            r_timeout <= 1'b1;
            r_state   <= ST_ARM;
          end else begin
            r_cnt <= r_cnt + DATA_W'(1);
            if (w_rise) begin
              r_edges <= w_edgesInc;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign res_if.period_int_o  = r_periodInt;
  assign res_if.period_frac_o = r_periodFrac;
  assign res_if.valid_o       = r_valid;
  assign overrun_o            = r_overrun;
  assign timeout_o            = r_timeout;

endmodule

// File: tb/tb_iob_nco_period_meter.sv
// Testbench for iob_nco_period_meter. Two instances: a 32-bit one for the
// averaging, handshake and enable/reset behaviour, and an 8-bit one so the
// counter timeout can be reached in a short run. A timestamp-based model
// predicts every output on every clock.
module tb_iob_nco_period_meter;

  localparam int SYNC = 2;

  logic       clk;
  logic       arstN;
  logic       cke;
  logic [1:0] sig = '0;
  logic [1:0] en, rdy, clr, manSig;
  logic [2:0] avg [2];
  logic       ovr0, tmo0, ovr1, tmo1;

  logic [1:0] genOn, genAlt;
  int         genPh [2];
  int         genPerA [2];
  int         genPerB [2];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iob_nco_period_meter_if #(.DATA_W(32)) if0 ();
  iob_nco_period_meter_if #(.DATA_W(8))  if1 ();
  assign if0.ready_i = rdy[0];
  assign if1.ready_i = rdy[1];

  iob_nco_period_meter #(.DATA_W(32), .AVG_LOG2_W(3), .SYNC_STAGES(SYNC)) dut0 (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arstN), .sig_i(sig[0]),
    .enable_i(en[0]), .avg_log2_i(avg[0]), .res_if(if0),
    .overrun_o(ovr0), .timeout_o(tmo0), .clear_i(clr[0]));

  iob_nco_period_meter #(.DATA_W(8), .AVG_LOG2_W(3), .SYNC_STAGES(SYNC)) dut1 (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arstN), .sig_i(sig[1]),
    .enable_i(en[1]), .avg_log2_i(avg[1]), .res_if(if1),
    .overrun_o(ovr1), .timeout_o(tmo1), .clear_i(clr[1]));

  // Reference model state: time stamps of window starts instead of counters.
  typedef enum {M_IDLE, M_ARM, M_MEAS} mode_t;
  mode_t       mMode [2];
  logic [3:0]  mHist [2];
  longint      mNow [2];
  longint      mStart [2];
  int          mEdges [2];
  int          mN [2];
  logic [31:0] mInt [2];
  logic [31:0] mFrac [2];
  logic        mValid [2];
  logic        mOvr [2];
  logic        mTmo [2];

  task automatic checkOutput(input string name, input logic [66:0] got, input logic [66:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [66:0] dutVec(input int d);
    if (d == 0)
      return {if0.valid_o, ovr0, tmo0, if0.period_int_o, if0.period_frac_o};
    return {if1.valid_o, ovr1, tmo1, 24'd0, if1.period_int_o, 24'd0, if1.period_frac_o};
  endfunction

  function automatic logic [66:0] modelVec(input int d);
    return {mValid[d], mOvr[d], mTmo[d], mInt[d], mFrac[d]};
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mMode[d] = M_IDLE; mHist[d] = '0; mNow[d] = 0; mStart[d] = 0;
      mEdges[d] = 0; mN[d] = 0; mInt[d] = '0; mFrac[d] = '0;
      mValid[d] = 1'b0; mOvr[d] = 1'b0; mTmo[d] = 1'b0;
    end
  endtask

  // One enabled clock of the meter, expressed as window arithmetic:
  // average = elapsed cycles / 2^n, fraction = remainder scaled to DATA_W bits.
  task automatic modelStep(input int d);
    int     dw;
    longint one, total, div, rem, cntBefore, mask;
    logic   rise, close, setOvr, setTmo;
    dw   = (d == 0) ? 32 : 8;
    one  = 1;
    mask = (one << dw) - 1;
    mHist[d] = {mHist[d][2:0], sig[d]};
    rise = mHist[d][SYNC] & ~mHist[d][SYNC+1];
    mNow[d] = mNow[d] + 1;
    cntBefore = mNow[d] - 1 - mStart[d];
    close = 1'b0; setOvr = 1'b0; setTmo = 1'b0;
    case (mMode[d])
      M_IDLE: if (en[d]) mMode[d] = M_ARM;
      M_ARM: begin
        if (rise) begin
          mStart[d] = mNow[d]; mEdges[d] = 0; mN[d] = int'(avg[d]); mMode[d] = M_MEAS;
        end else if (!en[d]) mMode[d] = M_IDLE;
      end
      default: begin
        if (!en[d]) mMode[d] = M_IDLE;
        else if (rise && (mEdges[d] + 1 == (1 << mN[d]))) close = 1'b1;
        else if (cntBefore == mask) begin setTmo = 1'b1; mMode[d] = M_ARM; end
        else if (rise) mEdges[d] = mEdges[d] + 1;
      end
    endcase
    if (close) begin
      total = mNow[d] - mStart[d];
      div   = one << mN[d];
      rem   = total % div;
      if (mValid[d] && !rdy[d]) setOvr = 1'b1;
      mValid[d] = 1'b1;
      mInt[d]   = 32'((total / div) & mask);
      mFrac[d]  = 32'(((rem << dw) / div) & mask);
      mStart[d] = mNow[d]; mEdges[d] = 0; mN[d] = int'(avg[d]);
    end else if (mValid[d] && rdy[d]) begin
      mValid[d] = 1'b0;
    end
    if (clr[d]) begin mOvr[d] = 1'b0; mTmo[d] = 1'b0; end
    if (setOvr) mOvr[d] = 1'b1;
    if (setTmo) mTmo[d] = 1'b1;
  endtask

  // Advance the model on each clock and compare both instances against it.
  always @(posedge clk) begin
    if (!arstN) modelReset();
    else if (cke) begin modelStep(0); modelStep(1); end
    #1;
    if (arstN) begin
      checkOutput("dut0 vs model", dutVec(0), modelVec(0));
      checkOutput("dut1 vs model", dutVec(1), modelVec(1));
    end
  end

  // Input waveform source: alternating periods A/B (high for half a period),
  // or a manually driven level when the generator is off.
  always @(negedge clk) begin
    int per;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (genOn[d]) begin
        per = genAlt[d] ? genPerB[d] : genPerA[d];
        sig[d] = (genPh[d] < per / 2);
        if (genPh[d] >= per - 1) begin
          genPh[d] = 0;
          genAlt[d] = ~genAlt[d];
        end else begin
          genPh[d] = genPh[d] + 1;
        end
      end else begin
        sig[d] = manSig[d];
        genPh[d] = 0;
        genAlt[d] = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input int d, input logic enV, input logic [2:0] avgV,
                               input logic rdyV, input int cycles);
    en[d] = enV; avg[d] = avgV; rdy[d] = rdyV;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitValid(input int d, input int maxCyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if ((d == 0) ? if0.valid_o : if1.valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("valid within bound", 67'(seen), 67'(1));
  endtask

  initial begin
    logic [31:0] a, b;
    arstN = 1'b0; cke = 1'b1;
    en = '0; rdy = '0; clr = '0; manSig = '0; genOn = '0;
    avg[0] = 3'd0; avg[1] = 3'd0;
    genPerA[0] = 10; genPerB[0] = 10; genPerA[1] = 20; genPerB[1] = 20;
    repeat (3) @(negedge clk);
    checkOutput("reset dut0", dutVec(0), 67'd0);
    checkOutput("reset dut1", dutVec(1), 67'd0);
    arstN = 1'b1;

    // Constant period 10, single-period windows, consumer always ready,
    // with a short clock-enable freeze early on.
    genOn[0] = 1'b1;
    applyStimulus(0, 1'b1, 3'd0, 1'b1, 15);
    cke = 1'b0;
    repeat (7) @(negedge clk);
    cke = 1'b1;
    repeat (80) @(negedge clk);
    checkOutput("p10 int", 67'(if0.period_int_o), 67'd10);
    checkOutput("p10 frac", 67'(if0.period_frac_o), 67'd0);
    checkOutput("p10 overrun", 67'(ovr0), 67'd0);

    // NCO-like 18.5-cycle average: periods alternate 18 and 19.
    applyStimulus(0, 1'b0, 3'd1, 1'b1, 2);
    genPerA[0] = 18; genPerB[0] = 19;
    repeat (40) @(negedge clk);
    applyStimulus(0, 1'b1, 3'd1, 1'b1, 200);
    checkOutput("avg2 int", 67'(if0.period_int_o), 67'd18);
    checkOutput("avg2 frac", 67'(if0.period_frac_o), 67'h80000000);

    applyStimulus(0, 1'b1, 3'd3, 1'b1, 400);
    checkOutput("avg8 int", 67'(if0.period_int_o), 67'd18);
    checkOutput("avg8 frac", 67'(if0.period_frac_o), 67'h80000000);
    applyStimulus(0, 1'b1, 3'd0, 1'b1, 5);
    checkOutput("avg change deferred int", 67'(if0.period_int_o), 67'd18);
    checkOutput("avg change deferred frac", 67'(if0.period_frac_o), 67'h80000000);
    repeat (300) @(negedge clk);
    waitValid(0, 40);
    a = if0.period_int_o;
    @(negedge clk);
    waitValid(0, 40);
    b = if0.period_int_o;
    checkOutput("alternating sum", 67'(a + b), 67'd37);
    checkOutput("alternating frac", 67'(if0.period_frac_o), 67'd0);

    // Unconsumed results: overrun, clear, then a single accept.
    applyStimulus(0, 1'b1, 3'd0, 1'b0, 60);
    checkOutput("overrun set", 67'(ovr0), 67'd1);
    checkOutput("overrun valid", 67'(if0.valid_o), 67'd1);
    applyStimulus(0, 1'b0, 3'd0, 1'b0, 3);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    checkOutput("overrun cleared", 67'(ovr0), 67'd0);
    checkOutput("valid kept", 67'(if0.valid_o), 67'd1);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    checkOutput("valid consumed", 67'(if0.valid_o), 67'd0);

    // Enable dropped mid-window discards it; re-enable measures again.
    applyStimulus(0, 1'b1, 3'd3, 1'b1, 60);
    applyStimulus(0, 1'b0, 3'd3, 1'b1, 200);
    checkOutput("disabled no result", 67'(if0.valid_o), 67'd0);
    applyStimulus(0, 1'b1, 3'd1, 1'b0, 150);
    checkOutput("reenable int", 67'(if0.period_int_o), 67'd18);
    checkOutput("reenable frac", 67'(if0.period_frac_o), 67'h80000000);

    // Asynchronous reset in the middle of a window.
    applyStimulus(0, 1'b1, 3'd1, 1'b0, 20);
    arstN = 1'b0;
    #1;
    checkOutput("async reset dut0", dutVec(0), 67'd0);
    checkOutput("async reset dut1", dutVec(1), 67'd0);
    repeat (2) @(negedge clk);
    arstN = 1'b1;
    repeat (150) @(negedge clk);
    checkOutput("after reset int", 67'(if0.period_int_o), 67'd18);
    checkOutput("after reset frac", 67'(if0.period_frac_o), 67'h80000000);
    applyStimulus(0, 1'b0, 3'd0, 1'b1, 2);

    // 8-bit instance: input stuck high after one rise saturates the counter.
    applyStimulus(1, 1'b1, 3'd0, 1'b0, 5);
    manSig[1] = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("timeout set", 67'(tmo1), 67'd1);
    checkOutput("timeout no result", 67'(if1.valid_o), 67'd0);
    manSig[1] = 1'b0;
    repeat (5) @(negedge clk);
    manSig[1] = 1'b1;
    repeat (10) @(negedge clk);
    manSig[1] = 1'b0;
    repeat (10) @(negedge clk);
    manSig[1] = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("after timeout valid", 67'(if1.valid_o), 67'd1);
    checkOutput("after timeout int", 67'(if1.period_int_o), 67'd20);
    checkOutput("timeout sticky", 67'(tmo1), 67'd1);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    checkOutput("timeout cleared", 67'(tmo1), 67'd0);
    applyStimulus(1, 1'b0, 3'd0, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
